// File: rtl/ct_merge_wrr.sv
// ct_merge_wrr: packet-atomic weighted round-robin merge of NI valid/ready/eop streams onto one output.
// Latency: 1 cycle from input transfer to o_valid, through a registered 2-entry skid stage.
// Backpressure: o_ready falls the cycle after the skid fills; i_ready never reaches o_ready combinationally.
// Optional: define CT_MERGE_WRR_HIPRI_EN to add i_hipri, which confines arbitration to the high-priority class.
module ct_merge_wrr #(
    parameter int NI    = 2,
    parameter int WIDTH = 32,
    parameter int QBITS = 4,
    localparam int NIBITS = (NI > 1) ? $clog2(NI) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NI*WIDTH-1:0] i_data,
    input  logic [NI-1:0]       i_valid,
    input  logic [NI-1:0]       i_eop,
    output logic [NI-1:0]       o_ready,
    input  logic [NI*QBITS-1:0] i_quota,
`ifdef CT_MERGE_WRR_HIPRI_EN
    input  logic [NI-1:0]       i_hipri,
`endif
    output logic                o_valid,
    output logic [WIDTH-1:0]    o_data,
    output logic                o_eop,
    input  logic                i_ready,
    output logic [NIBITS-1:0]   o_cur_input
);

    typedef enum logic {S_ARB, S_LOCKED} state_t;

    state_t            state;
    logic [NIBITS-1:0] last_input;
    logic [NIBITS-1:0] cur_input;
    logic [NIBITS-1:0] rr_pick;
    logic [NIBITS-1:0] rr_idx;
    logic              rr_found;
    logic [QBITS-1:0]  count;
    logic              tenure_open;
    logic [NI-1:0]     elig;

    logic              in_xfer;
    logic              in_eop;
    logic [WIDTH-1:0]  in_data;
    logic [QBITS-1:0]  quota_raw;
    logic [QBITS-1:0]  quota_eff;
    logic              new_tenure;
    logic [QBITS-1:0]  count_base;
    logic [QBITS-1:0]  count_inc;

    // second skid entry; the head entry is the output register itself
    logic              sk_vld;
    logic              sk_eop;
    logic [WIDTH-1:0]  sk_data;

    // channels competing at a packet boundary (high-priority class wins outright when present)
    always_comb begin
        elig = i_valid;
`ifdef CT_MERGE_WRR_HIPRI_EN
        if (|(i_valid & i_hipri)) begin
            elig = i_valid & i_hipri;
        end
`endif
    end

    // round-robin search starting after last_input; last_input itself is tried last
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_input;
        rr_idx   = last_input;
        for (int i = 1; i <= NI; i++) begin
            rr_idx = NIBITS'((int'(last_input) + i) % NI);
            if (!rr_found && elig[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // grant: locked packets keep their channel; an open tenure keeps the holder while it is eligible
    always_comb begin
        cur_input = last_input;
        if (state == S_ARB) begin
            if (tenure_open && elig[last_input]) begin
                cur_input = last_input;
            end else if (rr_found) begin
                cur_input = rr_pick;
            end
        end
    end

    // per-channel ready depends only on registered state, i_valid and reset
    always_comb begin
        o_ready            = '0;
        o_ready[cur_input] = !sk_vld && !reset;
    end

    assign in_xfer     = i_valid[cur_input] && !sk_vld && !reset;
    assign in_eop      = i_eop[cur_input];
    assign in_data     = i_data[int'(cur_input)*WIDTH +: WIDTH];
    assign quota_raw   = i_quota[int'(cur_input)*QBITS +: QBITS];
    assign quota_eff   = (quota_raw == '0) ? QBITS'(1) : quota_raw;
    assign new_tenure  = (state == S_ARB) && (!tenure_open || (cur_input != last_input));
    assign count_base  = new_tenure ? '0 : count;
    assign count_inc   = (&count_base) ? count_base : count_base + QBITS'(1);
    assign o_cur_input = cur_input;

    // packet FSM and tenure accounting; channel 0 starts with an open, unused tenure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_ARB;
            last_input  <= '0;
            count       <= '0;
            tenure_open <= 1'b1;
        end else if (in_xfer) begin
            if (state == S_ARB) begin
                last_input  <= cur_input;
                tenure_open <= 1'b1;
                count       <= count_base;
            end
            if (in_eop) begin
                state <= S_ARB;
                if (count_inc >= quota_eff) begin
                    count       <= '0;
                    tenure_open <= 1'b0;
                end else begin
                    count <= count_inc;
                end
            end else begin
                state <= S_LOCKED;
            end
        end
    end

    // 2-entry skid: a stalled head parks the in-flight beat in the second entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_eop   <= 1'b0;
            sk_vld  <= 1'b0;
            sk_data <= '0;
            sk_eop  <= 1'b0;
        end else if (o_valid && !i_ready) begin
            if (in_xfer) begin
                sk_vld  <= 1'b1;
                sk_data <= in_data;
                sk_eop  <= in_eop;
            end
        end else if (sk_vld) begin
            o_valid <= 1'b1;
            o_data  <= sk_data;
            o_eop   <= sk_eop;
            sk_vld  <= 1'b0;
        end else begin
            o_valid <= in_xfer;
            if (in_xfer) begin
                o_data <= in_data;
                o_eop  <= in_eop;
            end
        end
    end

endmodule

// File: tb/tb_ct_merge_wrr.sv
// tb_ct_merge_wrr: randomized and directed stimulus for ct_merge_wrr (NI=4) against a packet-level model.
// The model predicts grants from quota/round-robin rules and the output stream from an in-order beat queue.
// Define CT_MERGE_WRR_HIPRI_EN on both files to include the high-priority scenario.
module tb_ct_merge_wrr;
    localparam int NI = 4;
    localparam int W  = 32;
    localparam int QB = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NI*W-1:0]   i_data;
    logic [NI-1:0]     i_valid;
    logic [NI-1:0]     i_eop;
    logic [NI-1:0]     o_ready;
    logic [NI*QB-1:0]  i_quota;
    logic [NI-1:0]     hp;
    logic              o_valid;
    logic [W-1:0]      o_data;
    logic              o_eop;
    logic              i_ready;
    logic [1:0]        o_cur_input;

    ct_merge_wrr #(.NI(NI), .WIDTH(W), .QBITS(QB)) dut (
        .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .i_eop(i_eop),
        .o_ready(o_ready), .i_quota(i_quota),
`ifdef CT_MERGE_WRR_HIPRI_EN
        .i_hipri(hp),
`endif
        .o_valid(o_valid), .o_data(o_data), .o_eop(o_eop), .i_ready(i_ready),
        .o_cur_input(o_cur_input)
    );

    always #5 clk = ~clk;

    // source beats per channel: {eop, data}; data = {channel, packet id, beat index}
    logic [32:0] src [NI][128];
    int          head [NI];
    int          tail [NI];
    logic [NI-1:0] took;
    int          vprob, rprob;
    int          rdy_pat[$];

    // reference: beats accepted but not yet delivered, and tenure/round-robin bookkeeping
    logic [32:0] sb[$];
    logic        m_locked, m_open;
    int          m_last, m_used;
    int          grant_q[$], out_q[$];
    logic        out_first;
    int          bad_cur, bad_rdy, bad_vld, bad_dat, full_seen;
    int          in_beats, out_beats, cyc, first_in_cyc, last_out_cyc;
    logic [31:0] first_out_dat;
    int          errors = 0, checks = 0;

    function automatic int model_cur();
        logic [NI-1:0] el;
        if (m_locked) return m_last;
        el = (|(i_valid & hp)) ? (i_valid & hp) : i_valid;
        if (m_open && el[m_last]) return m_last;
        for (int i = 1; i <= NI; i++) if (el[(m_last + i) % NI]) return (m_last + i) % NI;
        return m_last;
    endfunction

    function automatic void model_xfer(int k, logic eop);
        int q;
        if (!m_locked) begin
            if (k != m_last || !m_open) m_used = 0;
            m_open = 1'b1;
            m_last = k;
            grant_q.push_back(k);
        end
        m_locked = !eop;
        if (eop) begin
            q = int'(i_quota[k*QB +: QB]);
            if (q == 0) q = 1;
            m_used++;
            if (m_used >= q) begin
                m_used = 0;
                m_open = 1'b0;
            end
        end
    endfunction

    function automatic logic pending();
        logic p;
        p = (sb.size() != 0) || (took != '0);
        for (int k = 0; k < NI; k++) if (head[k] < tail[k]) p = 1'b1;
        return p;
    endfunction

    task automatic add_pkt(int k, int id, int len);
        for (int b = 0; b < len; b++) begin
            src[k][tail[k]] = {(b == len - 1), 4'(k), 12'(id), 16'(b)};
            tail[k]++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        i_valid = '0; i_eop = '0; i_data = '0; i_ready = 1'b0; hp = '0; took = '0;
        for (int k = 0; k < NI; k++) begin head[k] = 0; tail[k] = 0; end
        sb.delete(); grant_q.delete(); out_q.delete(); rdy_pat.delete();
        m_locked = 1'b0; m_open = 1'b1; m_last = 0; m_used = 0; out_first = 1'b1;
        bad_cur = 0; bad_rdy = 0; bad_vld = 0; bad_dat = 0; full_seen = 0;
        in_beats = 0; out_beats = 0; first_in_cyc = -1; last_out_cyc = -1; first_out_dat = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // one clock: drive at negedge, observe 1 time unit later, account for the coming posedge transfers
    task automatic step();
        int c;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            if (took[k]) head[k]++;
            if (!(i_valid[k] && !took[k])) begin
                if (head[k] < tail[k] && $urandom_range(99) < vprob) begin
                    i_valid[k] = 1'b1;
                    i_data[k*W +: W] = src[k][head[k]][31:0];
                    i_eop[k] = src[k][head[k]][32];
                end else begin
                    i_valid[k] = 1'b0;
                    i_eop[k] = 1'b0;
                end
            end
        end
        if (rdy_pat.size() > 0) i_ready = (rdy_pat.pop_front() != 0);
        else i_ready = ($urandom_range(99) < rprob);
        #1;
        c = model_cur();
        if (o_cur_input !== 2'(c)) bad_cur++;
        for (int k = 0; k < NI; k++) if (o_ready[k] !== ((k == c) && (sb.size() < 2))) bad_rdy++;
        if (sb.size() == 2) full_seen++;
        if (o_valid !== (sb.size() != 0)) bad_vld++;
        if (o_valid && i_ready) begin
            if (sb.size() == 0) bad_dat++;
            else begin
                if ({o_eop, o_data} !== sb[0]) bad_dat++;
                sb.delete(0);
            end
            if (out_beats == 0) first_out_dat = o_data;
            if (out_first) out_q.push_back(int'(o_data[31:28]));
            out_first = o_eop;
            out_beats++;
            last_out_cyc = cyc;
        end
        took = i_valid & o_ready;
        for (int k = 0; k < NI; k++) begin
            if (took[k]) begin
                sb.push_back({i_eop[k], i_data[k*W +: W]});
                if (first_in_cyc < 0) first_in_cyc = cyc;
                in_beats++;
                model_xfer(k, i_eop[k]);
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = '0; i_eop = '0; i_data = '0; i_ready = 1'b1; hp = '0;
        i_quota = {NI{4'd1}};
        repeat (2) @(negedge clk);
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b required 0", o_valid); end
        checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_o_data: got %h required 0", o_data); end
        checks++; if (o_eop !== 1'b0) begin errors++; $display("FAIL reset_o_eop: got %b required 0", o_eop); end
        checks++; if (o_ready !== 4'b0000) begin errors++; $display("FAIL reset_o_ready: got %b required 0000", o_ready); end
        reset = 1'b0;
        @(negedge clk); #1;
        checks++; if (o_cur_input !== 2'd0) begin errors++; $display("FAIL idle_cur_input: got %0d required 0", o_cur_input); end
        checks++; if (o_ready !== 4'b0001) begin errors++; $display("FAIL idle_o_ready: got %b required 0001", o_ready); end
    endtask

    task automatic test_rr_order();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        apply_reset();
        i_quota = {NI{4'd1}}; vprob = 100; rprob = 100;
        for (int k = 0; k < NI; k++) begin add_pkt(k, 0, 2); add_pkt(k, 1, 2); end
        while (pending() && n < 400) begin step(); n++; end
        checks++; if (n >= 400) begin errors++; $display("FAIL rr_timeout: cycles %0d required < 400", n); end
        checks++; if (bad_cur + bad_rdy + bad_vld + bad_dat != 0) begin errors++;
            $display("FAIL rr_stream: cur=%0d rdy=%0d vld=%0d dat=%0d required all 0", bad_cur, bad_rdy, bad_vld, bad_dat); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (grant_q.size() <= i || grant_q[i] !== exp_g[i]) begin errors++;
                $display("FAIL rr_grant%0d: got %0d required %0d", i, (grant_q.size() > i) ? grant_q[i] : -1, exp_g[i]); end
        end
        checks++; if (out_q.size() != 8) begin errors++; $display("FAIL rr_out_pkts: got %0d required 8", out_q.size()); end
        checks++; if (last_out_cyc - first_in_cyc != 16) begin errors++;
            $display("FAIL rr_throughput: span %0d required 16", last_out_cyc - first_in_cyc); end
    endtask

    task automatic test_quota();
        int exp_g[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int n = 0;
        apply_reset();
        i_quota = {4'd1, 4'd1, 4'd1, 4'd3}; vprob = 100; rprob = 100;
        for (int p = 0; p < 12; p++) begin add_pkt(0, p, 1); add_pkt(1, p, 1); end
        while (pending() && n < 400) begin step(); n++; end
        checks++; if (n >= 400) begin errors++; $display("FAIL quota_timeout: cycles %0d required < 400", n); end
        checks++; if (bad_cur + bad_rdy + bad_vld + bad_dat != 0) begin errors++;
            $display("FAIL quota_stream: cur=%0d rdy=%0d vld=%0d dat=%0d required all 0", bad_cur, bad_rdy, bad_vld, bad_dat); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_q.size() <= i || out_q[i] !== exp_g[i]) begin errors++;
                $display("FAIL quota_seq%0d: got %0d required %0d", i, (out_q.size() > i) ? out_q[i] : -1, exp_g[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        apply_reset();
        i_quota = {NI{4'd1}}; vprob = 100; rprob = 100;
        rdy_pat = '{1, 0, 0, 1};
        add_pkt(0, 5, 5);
        while (pending() && n < 200) begin step(); n++; end
        checks++; if (n >= 200) begin errors++; $display("FAIL bp_timeout: cycles %0d required < 200", n); end
        checks++; if (bad_cur + bad_rdy + bad_vld + bad_dat != 0) begin errors++;
            $display("FAIL bp_stream: cur=%0d rdy=%0d vld=%0d dat=%0d required all 0", bad_cur, bad_rdy, bad_vld, bad_dat); end
        checks++; if (full_seen == 0) begin errors++; $display("FAIL bp_skid_full: full cycles %0d required > 0", full_seen); end
        checks++; if (out_beats != 5) begin errors++; $display("FAIL bp_beats: got %0d required 5", out_beats); end
    endtask

    task automatic test_idle_forfeit();
        int exp_g[10] = '{2, 3, 3, 2, 2, 2, 2, 3, 2, 3};
        int n = 0;
        apply_reset();
        i_quota = {4'd1, 4'd4, 4'd1, 4'd1}; vprob = 100; rprob = 100;
        add_pkt(2, 0, 1); add_pkt(3, 0, 1); add_pkt(3, 1, 1);
        while (pending() && n < 200) begin step(); n++; end
        for (int p = 0; p < 5; p++) add_pkt(2, 10 + p, 1);
        add_pkt(3, 10, 1); add_pkt(3, 11, 1);
        while (pending() && n < 400) begin step(); n++; end
        checks++; if (n >= 400) begin errors++; $display("FAIL forfeit_timeout: cycles %0d required < 400", n); end
        checks++; if (bad_cur + bad_rdy + bad_vld + bad_dat != 0) begin errors++;
            $display("FAIL forfeit_stream: cur=%0d rdy=%0d vld=%0d dat=%0d required all 0", bad_cur, bad_rdy, bad_vld, bad_dat); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_q.size() <= i || out_q[i] !== exp_g[i]) begin errors++;
                $display("FAIL forfeit_seq%0d: got %0d required %0d", i, (out_q.size() > i) ? out_q[i] : -1, exp_g[i]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        int n = 0;
        apply_reset();
        i_quota = {NI{4'd1}}; vprob = 100; rprob = 100;
        add_pkt(0, 3, 4);
        while (in_beats < 2 && n < 50) begin step(); n++; end
        checks++; if (n >= 50) begin errors++; $display("FAIL midrst_start: cycles %0d required < 50", n); end
        @(negedge clk);
        reset = 1'b1; i_valid = '0;
        #1;
        checks++; if ({o_valid, o_eop, o_ready} !== 6'b0 || o_data !== '0) begin errors++;
            $display("FAIL midrst_outputs: valid=%b eop=%b ready=%b data=%h required all 0", o_valid, o_eop, o_ready, o_data); end
        apply_reset();
        i_quota = {NI{4'd1}}; vprob = 100; rprob = 100;
        add_pkt(1, 7, 2);
        n = 0;
        while (pending() && n < 100) begin step(); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL midrst_timeout: cycles %0d required < 100", n); end
        checks++; if (first_out_dat !== {4'd1, 12'd7, 16'd0}) begin errors++;
            $display("FAIL midrst_first_beat: got %h required %h", first_out_dat, {4'd1, 12'd7, 16'd0}); end
        checks++; if (out_beats != 2 || bad_dat != 0) begin errors++;
            $display("FAIL midrst_beats: got %0d beats %0d bad required 2 beats 0 bad", out_beats, bad_dat); end
    endtask

    task automatic test_random();
        int n = 0, total = 0, len;
        apply_reset();
        for (int k = 0; k < NI; k++) i_quota[k*QB +: QB] = 4'($urandom_range(3));
        vprob = 60; rprob = 70;
        for (int k = 0; k < NI; k++)
            for (int p = 0; p < 15; p++) begin
                len = $urandom_range(4, 1);
                add_pkt(k, p, len);
                total += len;
            end
        while (pending() && n < 5000) begin step(); n++; end
        checks++; if (n >= 5000) begin errors++; $display("FAIL rand_timeout: cycles %0d required < 5000", n); end
        checks++; if (bad_cur + bad_rdy + bad_vld + bad_dat != 0) begin errors++;
            $display("FAIL rand_stream: cur=%0d rdy=%0d vld=%0d dat=%0d required all 0", bad_cur, bad_rdy, bad_vld, bad_dat); end
        checks++; if (out_beats != total) begin errors++; $display("FAIL rand_beats: got %0d required %0d", out_beats, total); end
        checks++; if (grant_q.size() != 60) begin errors++; $display("FAIL rand_grants: got %0d required 60", grant_q.size()); end
    endtask

`ifdef CT_MERGE_WRR_HIPRI_EN
    task automatic test_hipri();
        int exp_g[4] = '{0, 3, 3, 0};
        int n = 0;
        apply_reset();
        i_quota = {4'd2, 4'd1, 4'd1, 4'd3}; vprob = 100; rprob = 100;
        for (int p = 0; p < 6; p++) add_pkt(0, p, 1);
        while (grant_q.size() < 1 && n < 20) begin step(); n++; end
        hp = 4'b1000;
        add_pkt(3, 0, 1); add_pkt(3, 1, 1);
        while (pending() && n < 200) begin step(); n++; end
        checks++; if (n >= 200) begin errors++; $display("FAIL hipri_timeout: cycles %0d required < 200", n); end
        checks++; if (bad_cur + bad_rdy + bad_vld + bad_dat != 0) begin errors++;
            $display("FAIL hipri_stream: cur=%0d rdy=%0d vld=%0d dat=%0d required all 0", bad_cur, bad_rdy, bad_vld, bad_dat); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_q.size() <= i || out_q[i] !== exp_g[i]) begin errors++;
                $display("FAIL hipri_seq%0d: got %0d required %0d", i, (out_q.size() > i) ? out_q[i] : -1, exp_g[i]); end
        end
    endtask
`endif

    initial begin
        cyc = 0;
        test_reset();
        test_rr_order();
        test_quota();
        test_backpressure();
        test_idle_forfeit();
        test_reset_mid_packet();
        test_random();
`ifdef CT_MERGE_WRR_HIPRI_EN
        test_hipri();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end
endmodule
